// File: rtl/adc_sched_pkg.sv
// Shared constants and state encoding for the ADC scan scheduler and its round-robin picker.
package adc_sched_pkg;

   localparam int NCH         = 8;
   localparam int RW          = 12;
   localparam int CHW         = 3;
   localparam int DISCARD_CNT = 2;
   localparam int SKW         = 2;
   localparam int AVG_N       = 4;
   localparam int AVW         = 2;

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      DISCARD,
      CAPTURE
   } state_t;

endpackage

// File: rtl/adc_rr_pick.sv
// Combinational round-robin picker: first set mask bit strictly after cur, wrapping, with cur itself last.
module adc_rr_pick #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] cur,
   output logic [W-1:0] nxt,
   output logic         any
);

   logic [W-1:0] idx;

   // Walk from farthest to nearest so the nearest set bit after cur is the last one written.
   always_comb begin
      nxt = cur;
      any = |mask;
      idx = '0;
      for (int i = N; i >= 1; i--) begin
         idx = W'((int'(cur) + i) % N);
         if (mask[idx]) nxt = idx;
      end
   end

endmodule

// File: rtl/adc_scan_sched.sv
// Round-robin ADC scan scheduler: selects channels, skips stale conversions, captures results into a bank.
// Define ADC_SCAN_AVG_EN to capture the truncated mean of AVG_N samples instead of a single sample.
module adc_scan_sched
   import adc_sched_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic [NCH-1:0] chan_mask,
   input  logic           adc_convst,
   input  logic [RW-1:0]  adc_result,
   output logic [CHW-1:0] adc_chan,
   output logic           res_valid,
   output logic [CHW-1:0] res_chan,
   output logic [RW-1:0]  res_data,
   input  logic [CHW-1:0] rd_chan,
   output logic [RW-1:0]  rd_data,
   output logic           rd_fresh,
   input  logic           rd_ack
);

   state_t         state;
   logic           conv_q;
   logic           boundary;
   logic [CHW-1:0] cur;
   logic [CHW-1:0] nxt;
   logic           any;
   logic [SKW-1:0] skip;
   logic [RW-1:0]  bank [NCH];
   logic [NCH-1:0] fresh;
   logic [RW-1:0]  cap_val;
   logic           cap_last;

   assign boundary = adc_convst & ~conv_q;
   assign rd_data  = bank[rd_chan];
   assign rd_fresh = fresh[rd_chan];

`ifdef ADC_SCAN_AVG_EN
   logic [RW+1:0]  acc;
   logic [RW+1:0]  acc_sum;
   logic [AVW-1:0] n_samp;

   assign acc_sum  = acc + {2'b00, adc_result};
   assign cap_val  = acc_sum[RW+1:2];
   assign cap_last = (n_samp == AVW'(AVG_N - 1));
`else
   assign cap_val  = adc_result;
   assign cap_last = 1'b1;
`endif

   adc_rr_pick #(.N(NCH), .W(CHW)) u_pick (
      .mask (chan_mask),
      .cur  (cur),
      .nxt  (nxt),
      .any  (any)
   );

   // rd_ack clears first so a same-cycle capture to that channel leaves its fresh flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         conv_q    <= 1'b0;
         cur       <= CHW'(NCH - 1);
         skip      <= '0;
         adc_chan  <= '0;
         res_valid <= 1'b0;
         res_chan  <= '0;
         res_data  <= '0;
         fresh     <= '0;
         for (int i = 0; i < NCH; i++) bank[i] <= '0;
`ifdef ADC_SCAN_AVG_EN
         acc       <= '0;
         n_samp    <= '0;
`endif
      end else begin
         conv_q    <= adc_convst;
         res_valid <= 1'b0;
         if (rd_ack) fresh[rd_chan] <= 1'b0;

         if (!enable) begin
            state <= IDLE;
            skip  <= '0;
`ifdef ADC_SCAN_AVG_EN
            acc    <= '0;
            n_samp <= '0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (chan_mask != '0) state <= SELECT;
               end
               SELECT: begin
                  if (any) begin
                     adc_chan <= nxt;
                     cur      <= nxt;
                     skip     <= SKW'(DISCARD_CNT);
`ifdef ADC_SCAN_AVG_EN
                     acc    <= '0;
                     n_samp <= '0;
`endif
                     state    <= DISCARD;
                  end else begin
                     state <= IDLE;
                  end
               end
               DISCARD: begin
                  if (boundary) begin
                     if (skip != '0) begin
                        skip <= skip - 1'b1;
                     end else if (cap_last) begin
                        bank[cur]  <= cap_val;
                        fresh[cur] <= 1'b1;
                        res_data   <= cap_val;
                        res_chan   <= cur;
                        res_valid  <= 1'b1;
                        state      <= CAPTURE;
                     end
`ifdef ADC_SCAN_AVG_EN
                     else begin
                        acc    <= acc_sum;
                        n_samp <= n_samp + 1'b1;
                     end
`endif
                  end
               end
               CAPTURE: begin
                  state <= (chan_mask != '0) ? SELECT : IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_scan_sched.sv
// Randomized bench for adc_scan_sched against a boundary-counting scan model with a bank/fresh scoreboard.
// Honors ADC_SCAN_AVG_EN the same way as the design.
module tb_adc_scan_sched;
   import adc_sched_pkg::*;

`ifdef ADC_SCAN_AVG_EN
   localparam int NSAMP = AVG_N;
`else
   localparam int NSAMP = 1;
`endif

   logic           clk;
   logic           reset;
   logic           enable;
   logic [NCH-1:0] chan_mask;
   logic           adc_convst;
   logic [RW-1:0]  adc_result;
   logic [CHW-1:0] adc_chan;
   logic           res_valid;
   logic [CHW-1:0] res_chan;
   logic [RW-1:0]  res_data;
   logic [CHW-1:0] rd_chan;
   logic [RW-1:0]  rd_data;
   logic           rd_fresh;
   logic           rd_ack;

   int checks;
   int failures;

   // Scan model: which channel is being scanned, boundaries seen on it, and the bank contents.
   logic [RW-1:0] m_bank [NCH];
   bit            m_fresh [NCH];
   int            m_cur;
   int            m_chan;
   int            m_count;
   int            m_sum;
   int            m_rchan;
   int            m_rdata;
   bit            m_active;
   bit            m_valid;
   bit            m_conv_prev;
   bit            dir_result;

   adc_scan_sched dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .chan_mask  (chan_mask),
      .adc_convst (adc_convst),
      .adc_result (adc_result),
      .adc_chan   (adc_chan),
      .res_valid  (res_valid),
      .res_chan   (res_chan),
      .res_data   (res_data),
      .rd_chan    (rd_chan),
      .rd_data    (rd_data),
      .rd_fresh   (rd_fresh),
      .rd_ack     (rd_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rrNext(input logic [NCH-1:0] mask, input int from);
      logic [CHW-1:0] idx;
      for (int k = 1; k <= NCH; k++) begin
         idx = CHW'((from + k) % NCH);
         if (mask[idx]) return int'(idx);
      end
      return from;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < NCH; i++) begin
         m_bank[i]  = '0;
         m_fresh[i] = 1'b0;
      end
      m_cur = NCH - 1;
      m_chan = 0;
      m_count = 0;
      m_sum = 0;
      m_rchan = 0;
      m_rdata = 0;
      m_active = 1'b0;
      m_valid = 1'b0;
      m_conv_prev = 1'b0;
   endtask

   // One clock: drive at negedge, advance the model for the coming edge, compare #1 after it.
   task automatic applyStimulus(input bit conv, input bit ack, input int rch);
      bit bnd;
      int val;
      adc_convst = conv;
      rd_ack     = ack;
      rd_chan    = CHW'(rch);
      adc_result = dir_result ? RW'(m_chan * 100) : RW'($urandom);
      bnd = conv && !m_conv_prev;
      m_conv_prev = conv;
      m_valid = 1'b0;
      if (bnd) checkOutput("adc_chan_at_boundary", 32'(adc_chan), 32'(m_chan));
      if (ack) m_fresh[rch] = 1'b0;
      if (bnd && m_active) begin
         m_count++;
         if (m_count > DISCARD_CNT) begin
            m_sum += int'(adc_result);
            if (m_count == DISCARD_CNT + NSAMP) begin
               val = m_sum / NSAMP;
               m_bank[m_cur]  = RW'(val);
               m_fresh[m_cur] = 1'b1;
               m_valid = 1'b1;
               m_rchan = m_cur;
               m_rdata = val;
               m_count = 0;
               m_sum = 0;
               if (chan_mask != '0) begin
                  m_cur  = rrNext(chan_mask, m_cur);
                  m_chan = m_cur;
               end else begin
                  m_active = 1'b0;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      checkOutput("res_valid", 32'(res_valid), 32'(m_valid));
      checkOutput("res_chan", 32'(res_chan), 32'(m_rchan));
      checkOutput("res_data", 32'(res_data), 32'(m_rdata));
      checkOutput("rd_data", 32'(rd_data), 32'(m_bank[rch]));
      checkOutput("rd_fresh", 32'(rd_fresh), 32'(m_fresh[rch]));
      @(negedge clk);
   endtask

   // A slot: settings change, low gap, a two-cycle convst pulse, then quiet guard cycles.
   task automatic runSlot(input bit en, input logic [NCH-1:0] mask, input int gap, input bit ack_three);
      enable    = en;
      chan_mask = mask;
      if (!en) begin
         m_active = 1'b0;
         m_count = 0;
         m_sum = 0;
      end else if (!m_active && mask != '0) begin
         m_cur    = rrNext(mask, m_cur);
         m_chan   = m_cur;
         m_active = 1'b1;
         m_count  = 0;
         m_sum    = 0;
      end
      for (int i = 0; i < gap; i++) begin
         if (i == 2) checkOutput("adc_chan_settled", 32'(adc_chan), 32'(m_chan));
         applyStimulus(1'b0, $urandom_range(0, 3) == 0, int'($urandom_range(0, NCH - 1)));
      end
      for (int i = 0; i < 2; i++) begin
         if (ack_three) applyStimulus(1'b1, 1'b1, 3);
         else applyStimulus(1'b1, $urandom_range(0, 3) == 0, int'($urandom_range(0, NCH - 1)));
      end
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, $urandom_range(0, 3) == 0, int'($urandom_range(0, NCH - 1)));
   endtask

   task automatic doReset();
      reset      = 1'b1;
      adc_convst = 1'b0;
      rd_ack     = 1'b0;
      @(posedge clk);
      #1;
      modelReset();
      checkOutput("reset_adc_chan", 32'(adc_chan), 32'd0);
      checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
      checkOutput("reset_res_chan", 32'(res_chan), 32'd0);
      checkOutput("reset_res_data", 32'(res_data), 32'd0);
      checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
      checkOutput("reset_rd_fresh", 32'(rd_fresh), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      enable = 1'b0;
      chan_mask = '0;
      adc_convst = 1'b0;
      adc_result = '0;
      rd_ack = 1'b0;
      rd_chan = '0;
      dir_result = 1'b1;
      modelReset();
      @(negedge clk);
      doReset();

      for (int s = 0; s < 12; s++) runSlot(1'b1, 8'h05, 8, 1'b0);
      dir_result = 1'b0;
      for (int s = 0; s < 9; s++) runSlot(1'b1, 8'h80, 7, 1'b0);
      for (int s = 0; s < 3; s++) runSlot(1'b1, 8'h00, 7, 1'b0);
      for (int s = 0; s < 6; s++) runSlot(1'b1, 8'h10, 7, 1'b0);

      runSlot(1'b1, 8'h02, 7, 1'b0);
      runSlot(1'b0, 8'h02, 7, 1'b0);
      for (int s = 0; s < 7; s++) runSlot(1'b1, 8'h02, 7, 1'b0);

      for (int s = 0; s < 9; s++) runSlot(1'b1, 8'h08, 7, 1'b1);

      for (int s = 0; s < 70; s++) begin
         if ($urandom_range(0, 24) == 0) doReset();
         runSlot($urandom_range(0, 9) != 0,
                 ($urandom_range(0, 5) == 0) ? 8'h00 : NCH'($urandom),
                 int'($urandom_range(6, 10)), $urandom_range(0, 4) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
